// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared constants, state type and address helpers for the fetch memory
package inst_mem_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0033;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PROG = 1'b1
  } state_t;

  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction

  // Misaligned PCs and PCs past the end of storage both fault.
  function automatic logic addr_fault(input logic [63:0] addr, input logic [63:0] depth);
    return (addr[1:0] != 2'b00) || (addr >= (depth << 2));
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - DEPTH x XLEN storage, one write port, one registered read-first read port
module inst_mem_array #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [XLEN-1:0]  o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  // Read holds its value unless a new read is issued, which keeps responses stable under backpressure.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_mem_fetch.sv
// rtl/inst_mem_fetch.sv - IF-stage instruction memory with valid/ready fetch port and streaming program load
module inst_mem_fetch #(
  parameter  int              XLEN     = 32,
  parameter  int              DEPTH    = 64,
  parameter  int              ADDR_W   = 32,
  parameter  logic [XLEN-1:0] NOP_INST = inst_mem_pkg::NOP_INST,
  localparam int              IDX_W    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_req_ready,
  input  logic              i_flush,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [XLEN-1:0]   o_rsp_inst,
  output logic [ADDR_W-1:0] o_rsp_pc,
  output logic              o_rsp_fault,
  input  logic              i_prog_en,
  input  logic              i_prog_valid,
  input  logic [XLEN-1:0]   i_prog_data,
  output logic [IDX_W:0]    o_prog_cnt
);
  import inst_mem_pkg::*;

  state_t            r_state, w_state_nxt;
  logic              r_rsp_valid, r_rsp_fault, r_inst_ok;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [IDX_W-1:0]  r_wptr;
  logic [IDX_W:0]    r_prog_cnt;
  logic              w_req_ready, w_accept, w_we, w_enter_prog, w_fault;
  logic [63:0]       w_addr64;
  logic [IDX_W-1:0]  w_ridx;
  logic [XLEN-1:0]   w_rdata;

  assign w_addr64 = 64'(i_req_addr);
  assign w_ridx   = IDX_W'(addr_to_idx(w_addr64));
  assign w_fault  = addr_fault(w_addr64, 64'(DEPTH));
  assign w_accept = i_req_valid && w_req_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 1'b0;
    w_we         = 1'b0;
    w_enter_prog = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_req_ready = !i_flush && !i_prog_en && (!r_rsp_valid || i_rsp_ready);
        if (i_prog_en) begin
          w_state_nxt  = ST_PROG;
          w_enter_prog = 1'b1;
        end
      end
      ST_PROG: begin
        // The cycle that leaves PROG drops its prog_valid beat.
        w_we = i_prog_en && i_prog_valid;
        if (!i_prog_en) w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_inst_ok   <= 1'b0;
      r_rsp_pc    <= '0;
      r_wptr      <= '0;
      r_prog_cnt  <= '0;
    end else begin
      if (w_enter_prog || (r_state == ST_PROG) || i_flush) r_rsp_valid <= 1'b0;
      else if (w_accept)                                   r_rsp_valid <= 1'b1;
      else if (i_rsp_ready)                                r_rsp_valid <= 1'b0;

      if (w_accept) begin
        r_rsp_pc    <= i_req_addr;
        r_rsp_fault <= w_fault;
        r_inst_ok   <= !w_fault;
      end

      if (w_enter_prog) begin
        r_wptr     <= '0;
        r_prog_cnt <= '0;
      end else if (w_we) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_prog_cnt != (IDX_W+1)'(DEPTH)) r_prog_cnt <= r_prog_cnt + 1'b1;
      end
    end
  end

  inst_mem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (i_prog_data),
    .i_re    (w_accept),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata)
  );

  // r_inst_ok clears asynchronously, so reset shows NOP without touching the array.
  assign o_rsp_inst  = r_inst_ok ? w_rdata : NOP_INST;
  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_pc    = r_rsp_pc;
  assign o_rsp_fault = r_rsp_fault;
  assign o_prog_cnt  = r_prog_cnt;

endmodule
